// File: rtl/tx_scheduler_rr.sv
// Round-robin transmit scheduler. It keeps eligible, busy and pending state
// for each queue and issues one request per pick through a PIPELINE-deep
// arbitration path into a registered valid/ready output. An op table tracks
// the outstanding requests, and the tag of each request is its op-table index.
module tx_scheduler_rr #(
    parameter int LEN_WIDTH         = 16,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int OP_TABLE_SIZE     = 16,
    parameter int QUEUE_INDEX_WIDTH = 6,
    parameter int PIPELINE          = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_tx_req_queue,
    output logic [REQ_TAG_WIDTH-1:0]     m_axis_tx_req_tag,
    output logic                         m_axis_tx_req_valid,
    input  logic                         m_axis_tx_req_ready,
    input  logic [LEN_WIDTH-1:0]         s_axis_tx_req_status_len,
    input  logic [REQ_TAG_WIDTH-1:0]     s_axis_tx_req_status_tag,
    input  logic                         s_axis_tx_req_status_valid,
    input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_doorbell_queue,
    input  logic                         s_axis_doorbell_valid,
    input  logic                         enable,
    output logic                         active
);

    localparam int NQ       = 2 ** QUEUE_INDEX_WIDTH;
    localparam int OP_IDX_W = (OP_TABLE_SIZE > 1) ? $clog2(OP_TABLE_SIZE) : 1;

    // Per-queue scheduling state
    logic [NQ-1:0]                r_eligible;
    logic [NQ-1:0]                r_busy;
    logic [NQ-1:0]                r_pending;
    logic [NQ-1:0]                w_eligible_nxt;
    logic [NQ-1:0]                w_busy_nxt;
    logic [NQ-1:0]                w_pending_nxt;
    logic [QUEUE_INDEX_WIDTH-1:0] r_rr_ptr;

    // Op table: one entry per outstanding request
    logic [OP_TABLE_SIZE-1:0]     r_op_used;
    logic [OP_TABLE_SIZE-1:0]     w_op_used_nxt;
    logic [QUEUE_INDEX_WIDTH-1:0] r_op_queue [OP_TABLE_SIZE];

    // Arbitration results
    logic                         w_arb_hit_hi;
    logic [QUEUE_INDEX_WIDTH-1:0] w_arb_q_hi;
    logic                         w_arb_hit_any;
    logic [QUEUE_INDEX_WIDTH-1:0] w_arb_q_any;
    logic                         w_free_hit;
    logic [OP_IDX_W-1:0]          w_free_idx;
    logic                         w_adv;
    logic                         w_pick;
    logic [QUEUE_INDEX_WIDTH-1:0] w_pick_q;
    logic [REQ_TAG_WIDTH-1:0]     w_pick_tag;

    // Completion decode
    logic [OP_IDX_W-1:0]          w_cpl_idx;
    logic                         w_cpl_ok;
    logic [QUEUE_INDEX_WIDTH-1:0] w_cpl_q;
    logic                         w_cpl_again;

    // Arbitration pipeline and output register
    logic                         r_vld_p   [PIPELINE];
    logic [QUEUE_INDEX_WIDTH-1:0] r_queue_p [PIPELINE];
    logic [REQ_TAG_WIDTH-1:0]     r_tag_p   [PIPELINE];
    logic                         r_out_valid;
    logic [QUEUE_INDEX_WIDTH-1:0] r_out_queue;
    logic [REQ_TAG_WIDTH-1:0]     r_out_tag;
    logic                         w_out_valid_nxt;
    logic                         r_active;

    assign m_axis_tx_req_valid = r_out_valid;
    assign m_axis_tx_req_queue = r_out_queue;
    assign m_axis_tx_req_tag   = r_out_tag;
    assign active              = r_active;

    // Round-robin search: the lowest eligible queue above the pointer, else the lowest eligible queue overall
    always_comb begin
        w_arb_hit_hi  = 1'b0;
        w_arb_q_hi    = '0;
        w_arb_hit_any = 1'b0;
        w_arb_q_any   = '0;
        for (int i = NQ - 1; i >= 0; i--) begin
            if (r_eligible[i]) begin
                w_arb_hit_any = 1'b1;
                w_arb_q_any   = QUEUE_INDEX_WIDTH'(i);
                if (i > int'(r_rr_ptr)) begin
                    w_arb_hit_hi = 1'b1;
                    w_arb_q_hi   = QUEUE_INDEX_WIDTH'(i);
                end
            end
        end
    end

    // Lowest free op-table entry; a search from the top down leaves the lowest index
    always_comb begin
        w_free_hit = 1'b0;
        w_free_idx = '0;
        for (int i = OP_TABLE_SIZE - 1; i >= 0; i--) begin
            if (!r_op_used[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = OP_IDX_W'(i);
            end
        end
    end

    // Pick qualification; the whole arbitration path moves only when the output can take a new word
    always_comb begin
        w_adv      = !r_out_valid || m_axis_tx_req_ready;
        w_pick     = enable && w_free_hit && w_adv && w_arb_hit_any;
        w_pick_q   = w_arb_hit_hi ? w_arb_q_hi : w_arb_q_any;
        w_pick_tag = '0;
        w_pick_tag[OP_IDX_W-1:0] = w_free_idx;
    end

    // Completion decode; out-of-range tags and tags of free entries are dropped
    always_comb begin
        w_cpl_idx   = s_axis_tx_req_status_tag[OP_IDX_W-1:0];
        w_cpl_ok    = s_axis_tx_req_status_valid
                      && (int'(s_axis_tx_req_status_tag) < OP_TABLE_SIZE)
                      && r_op_used[w_cpl_idx];
        w_cpl_q     = r_op_queue[w_cpl_idx];
        w_cpl_again = (s_axis_tx_req_status_len != '0);
    end

    // Per-queue next state: a pick, a completion and a doorbell can all arrive in one cycle
    always_comb begin
        w_eligible_nxt = r_eligible;
        w_busy_nxt     = r_busy;
        w_pending_nxt  = r_pending;
        for (int i = 0; i < NQ; i++) begin
            logic db_hit;
            logic cpl_hit;
            logic pick_hit;
            db_hit   = s_axis_doorbell_valid && (int'(s_axis_doorbell_queue) == i);
            cpl_hit  = w_cpl_ok && (int'(w_cpl_q) == i);
            pick_hit = w_pick && (int'(w_pick_q) == i);
            if (pick_hit) begin
                w_eligible_nxt[i] = 1'b0;
                w_busy_nxt[i]     = 1'b1;
            end
            if (cpl_hit) begin
                // A doorbell in the same cycle counts as pending
                w_busy_nxt[i]    = 1'b0;
                w_pending_nxt[i] = 1'b0;
                if (w_cpl_again || r_pending[i] || db_hit) begin
                    w_eligible_nxt[i] = 1'b1;
                end
            end else if (db_hit) begin
                if (r_busy[i] || pick_hit) begin
                    w_pending_nxt[i] = 1'b1;
                end else begin
                    w_eligible_nxt[i] = 1'b1;
                end
            end
        end
    end

    // Op-table occupancy: a completion frees its entry and a pick allocates a different one
    always_comb begin
        w_op_used_nxt = r_op_used;
        if (w_cpl_ok) begin
            w_op_used_nxt[w_cpl_idx] = 1'b0;
        end
        if (w_pick) begin
            w_op_used_nxt[w_free_idx] = 1'b1;
        end
        w_out_valid_nxt = w_adv ? r_vld_p[PIPELINE-1] : r_out_valid;
    end

    // Queue state, op table and round-robin pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_eligible <= '0;
            r_busy     <= '0;
            r_pending  <= '0;
            r_op_used  <= '0;
            r_rr_ptr   <= '1;
            for (int i = 0; i < OP_TABLE_SIZE; i++) begin
                r_op_queue[i] <= '0;
            end
        end else begin
            r_eligible <= w_eligible_nxt;
            r_busy     <= w_busy_nxt;
            r_pending  <= w_pending_nxt;
            r_op_used  <= w_op_used_nxt;
            if (w_pick) begin
                r_rr_ptr               <= w_pick_q;
                r_op_queue[w_free_idx] <= w_pick_q;
            end
        end
    end

    // Arbitration pipeline stages; they shift together whenever the output advances
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PIPELINE; k++) begin
                r_vld_p[k]   <= 1'b0;
                r_queue_p[k] <= '0;
                r_tag_p[k]   <= '0;
            end
        end else if (w_adv) begin
            r_vld_p[0]   <= w_pick;
            r_queue_p[0] <= w_pick_q;
            r_tag_p[0]   <= w_pick_tag;
            for (int k = 1; k < PIPELINE; k++) begin
                r_vld_p[k]   <= r_vld_p[k-1];
                r_queue_p[k] <= r_queue_p[k-1];
                r_tag_p[k]   <= r_tag_p[k-1];
            end
        end
    end

    // Output register; queue and tag change only when a new request is loaded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_queue <= '0;
            r_out_tag   <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_vld_p[PIPELINE-1];
            if (r_vld_p[PIPELINE-1]) begin
                r_out_queue <= r_queue_p[PIPELINE-1];
                r_out_tag   <= r_tag_p[PIPELINE-1];
            end
        end
    end

    // Activity flag, computed from next-state values so it matches the registered state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
        end else begin
            r_active <= (|w_eligible_nxt) || (|w_op_used_nxt) || w_out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_tx_scheduler_rr.sv
// Directed bench for tx_scheduler_rr: latency, ordering, rescheduling,
// op-table exhaustion, backpressure, enable and reset behaviour.
module tb_tx_scheduler_rr;

    localparam int PIPE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  m_axis_tx_req_queue;
    logic [7:0]  m_axis_tx_req_tag;
    logic        m_axis_tx_req_valid;
    logic        m_axis_tx_req_ready = 1'b1;
    logic [15:0] s_axis_tx_req_status_len = '0;
    logic [7:0]  s_axis_tx_req_status_tag = '0;
    logic        s_axis_tx_req_status_valid = 1'b0;
    logic [5:0]  s_axis_doorbell_queue = '0;
    logic        s_axis_doorbell_valid = 1'b0;
    logic        enable = 1'b1;
    logic        active;

    int n_checks = 0;
    int n_errors = 0;
    int mon_q[$];
    int mon_t[$];

    tx_scheduler_rr #(
        .LEN_WIDTH(16), .REQ_TAG_WIDTH(8), .OP_TABLE_SIZE(16),
        .QUEUE_INDEX_WIDTH(6), .PIPELINE(PIPE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m_axis_tx_req_queue(m_axis_tx_req_queue),
        .m_axis_tx_req_tag(m_axis_tx_req_tag),
        .m_axis_tx_req_valid(m_axis_tx_req_valid),
        .m_axis_tx_req_ready(m_axis_tx_req_ready),
        .s_axis_tx_req_status_len(s_axis_tx_req_status_len),
        .s_axis_tx_req_status_tag(s_axis_tx_req_status_tag),
        .s_axis_tx_req_status_valid(s_axis_tx_req_status_valid),
        .s_axis_doorbell_queue(s_axis_doorbell_queue),
        .s_axis_doorbell_valid(s_axis_doorbell_valid),
        .enable(enable),
        .active(active)
    );

    always #5 clk = ~clk;

    // Record every accepted request (valid and ready stable between edges)
    always @(negedge clk) begin
        if (rst && m_axis_tx_req_valid && m_axis_tx_req_ready) begin
            mon_q.push_back(int'(m_axis_tx_req_queue));
            mon_t.push_back(int'(m_axis_tx_req_tag));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic ring(input int q);
        s_axis_doorbell_queue = 6'(q);
        s_axis_doorbell_valid = 1'b1;
        tick();
        s_axis_doorbell_valid = 1'b0;
    endtask

    task automatic cpl(input int tag, input int len);
        s_axis_tx_req_status_tag   = 8'(tag);
        s_axis_tx_req_status_len   = 16'(len);
        s_axis_tx_req_status_valid = 1'b1;
        tick();
        s_axis_tx_req_status_valid = 1'b0;
    endtask

    task automatic clr_mon();
        mon_q.delete();
        mon_t.delete();
    endtask

    task automatic chk_count(input string nm, input int n);
        check(nm, mon_q.size(), n);
    endtask

    task automatic chk_x(input string nm, input int idx, input int q, input int t);
        check({nm, "_queue"}, (idx < mon_q.size()) ? mon_q[idx] : -1, q);
        check({nm, "_tag"},   (idx < mon_t.size()) ? mon_t[idx] : -1, t);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(m_axis_tx_req_valid), 0);
        check("rst_queue", int'(m_axis_tx_req_queue), 0);
        check("rst_tag", int'(m_axis_tx_req_tag), 0);
        check("rst_active", int'(active), 0);
        rst = 1'b1;
        tick();

        // Single doorbell: valid appears exactly PIPE+1 edges after the sampling edge
        ring(1);
        @(negedge clk);
        check("db_active", int'(active), 1);
        for (int k = 1; k <= PIPE; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("lat_early", int'(m_axis_tx_req_valid), 0);
        end
        @(posedge clk);
        @(negedge clk);
        check("lat_valid", int'(m_axis_tx_req_valid), 1);
        check("lat_queue", int'(m_axis_tx_req_queue), 1);
        check("lat_tag", int'(m_axis_tx_req_tag), 0);
        #1;
        run(10);
        chk_count("single_n", 1);
        chk_x("single", 0, 1, 0);
        clr_mon();

        // Bogus completions ignored, second queue takes tag 1, completions drain
        cpl(2, 0);
        cpl(20, 5);
        ring(2);
        run(8);
        chk_count("q2_n", 1);
        chk_x("q2", 0, 2, 1);
        clr_mon();
        cpl(1, 0);
        check("active_one_left", int'(active), 1);
        cpl(0, 0);
        check("active_drained", int'(active), 0);
        run(6);
        chk_count("no_resched_n", 0);

        // Three doorbells collected while disabled, issued in round-robin order
        enable = 1'b0;
        ring(5);
        ring(3);
        ring(9);
        tick();
        chk_count("disabled_n", 0);
        check("disabled_active", int'(active), 1);
        enable = 1'b1;
        run(12);
        chk_count("rr_n", 3);
        chk_x("rr0", 0, 3, 0);
        chk_x("rr1", 1, 5, 1);
        chk_x("rr2", 2, 9, 2);
        clr_mon();
        cpl(0, 0);
        cpl(1, 0);
        cpl(2, 0);
        check("rr_drained", int'(active), 0);

        // Pending doorbell, len!=0 completion, and doorbell+completion in one cycle
        ring(4);
        run(8);
        chk_count("q4_n", 1);
        chk_x("q4", 0, 4, 0);
        clr_mon();
        ring(4);
        run(5);
        chk_count("q4_pending_hold_n", 0);
        cpl(0, 0);
        run(8);
        chk_count("q4_pend_n", 1);
        chk_x("q4_pend", 0, 4, 0);
        clr_mon();
        cpl(0, 100);
        run(8);
        chk_count("q4_len_n", 1);
        chk_x("q4_len", 0, 4, 0);
        clr_mon();
        s_axis_doorbell_queue = 6'd4;
        s_axis_doorbell_valid = 1'b1;
        cpl(0, 0);
        s_axis_doorbell_valid = 1'b0;
        run(8);
        chk_count("q4_same_n", 1);
        chk_x("q4_same", 0, 4, 0);
        clr_mon();
        cpl(0, 0);
        run(8);
        chk_count("q4_idle_n", 0);
        check("q4_idle_active", int'(active), 0);

        // Seventeen queues against a sixteen-entry op table
        enable = 1'b0;
        for (int i = 0; i < 17; i++) ring(10 + i);
        enable = 1'b1;
        run(40);
        chk_count("full_n", 16);
        for (int i = 0; i < 16; i++) chk_x("full", i, 10 + i, i);
        clr_mon();
        ring(27);
        run(8);
        chk_count("full_db_n", 0);
        check("full_active", int'(active), 1);
        cpl(7, 0);
        run(8);
        chk_count("freed7_n", 1);
        chk_x("freed7", 0, 26, 7);
        clr_mon();
        cpl(8, 0);
        run(8);
        chk_count("freed8_n", 1);
        chk_x("freed8", 0, 27, 8);
        clr_mon();
        for (int i = 0; i < 16; i++) cpl(i, 0);
        check("full_drained", int'(active), 0);

        // Backpressure holds the output; enable=0 stops further picks
        m_axis_tx_req_ready = 1'b0;
        ring(30);
        repeat (PIPE + 1) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", int'(m_axis_tx_req_valid), 1);
            check("hold_queue", int'(m_axis_tx_req_queue), 30);
            check("hold_tag", int'(m_axis_tx_req_tag), 0);
            @(posedge clk);
        end
        #1;
        enable = 1'b0;
        ring(31);
        m_axis_tx_req_ready = 1'b1;
        run(10);
        chk_count("en_off_n", 1);
        chk_x("en_off", 0, 30, 0);
        check("en_off_valid", int'(m_axis_tx_req_valid), 0);
        check("en_off_active", int'(active), 1);
        clr_mon();
        enable = 1'b1;
        run(10);
        chk_count("en_on_n", 1);
        chk_x("en_on", 0, 31, 1);
        clr_mon();

        // Asynchronous reset with two ops outstanding
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", int'(m_axis_tx_req_valid), 0);
        check("mid_rst_queue", int'(m_axis_tx_req_queue), 0);
        check("mid_rst_tag", int'(m_axis_tx_req_tag), 0);
        check("mid_rst_active", int'(active), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpl(0, 100);
        cpl(1, 5);
        run(8);
        chk_count("post_rst_n", 0);
        check("post_rst_active", int'(active), 0);
        ring(12);
        run(8);
        chk_count("post_rst_db_n", 1);
        chk_x("post_rst_db", 0, 12, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tx_scheduler_rr.md
TX_SCHEDULER_RR -- requirements
Module: tx_scheduler_rr

Interface
REQ-001 SHALL provide parameter LEN_WIDTH, default 16: width of the completion status length.
REQ-002 SHALL provide parameter REQ_TAG_WIDTH, default 8: width of the request/completion tag.
REQ-003 SHALL provide parameter OP_TABLE_SIZE, default 16: maximum number of outstanding requests, at most 2^REQ_TAG_WIDTH.
REQ-004 SHALL provide parameter QUEUE_INDEX_WIDTH, default 6: the block schedules 2^QUEUE_INDEX_WIDTH queues.
REQ-005 SHALL provide parameter PIPELINE, default 2: number of register stages in the arbitration path, at least 1.
REQ-006 SHALL have one clock and an asynchronous, active-low reset; all state is clocked on the rising edge of the clock.
REQ-007 SHALL have clk, input, 1 bit: the single clock.
REQ-008 SHALL have rst, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have m_axis_tx_req_queue, output, QUEUE_INDEX_WIDTH bits: the queue being scheduled.
REQ-010 SHALL have m_axis_tx_req_tag, output, REQ_TAG_WIDTH bits: the op-table index assigned to the request.
REQ-011 SHALL have m_axis_tx_req_valid, output, 1 bit, and m_axis_tx_req_ready, input, 1 bit: the request handshake.
REQ-012 SHALL have s_axis_tx_req_status_len, input, LEN_WIDTH bits, s_axis_tx_req_status_tag, input, REQ_TAG_WIDTH bits, and s_axis_tx_req_status_valid, input, 1 bit: the completion interface, which has no ready signal.
REQ-013 SHALL have s_axis_doorbell_queue, input, QUEUE_INDEX_WIDTH bits, and s_axis_doorbell_valid, input, 1 bit: the doorbell interface, which has no ready signal and accepts every cycle.
REQ-014 SHALL have enable, input, 1 bit: permits issuing new requests.
REQ-015 SHALL have active, output, 1 bit: the scheduler holds work.

Function
REQ-016 SHALL keep, per queue, an eligible bit (waiting in round-robin), a busy bit (request outstanding) and a pending bit (doorbell arrived while busy).
REQ-017 Doorbell on queue q: if q is idle, SHALL set eligible[q]; if q is busy, SHALL set pending[q]; if q is already eligible, there is no change (no duplicates).
REQ-018 Arbitration SHALL pick the lowest-indexed eligible queue strictly after the last-issued queue, wrapping from 2^QUEUE_INDEX_WIDTH-1 to 0; the pointer resets to 2^QUEUE_INDEX_WIDTH-1, so the first pick is the lowest eligible index.
REQ-019 A pick SHALL occur only when enable=1, a free op-table entry exists, and the output register is empty or handshaking.
REQ-020 On a pick, the queue SHALL go eligible->busy and the op-table entry with the lowest free index SHALL be allocated, recording the queue; the tag equals the entry index.
REQ-021 Latency SHALL be that a doorbell sampled at edge N on an idle scheduler gives m_axis_tx_req_valid=1 after edge N+PIPELINE+1.
REQ-022 Output SHALL be registered; valid with queue/tag stays stable until ready=1 at a rising edge; a transfer then completes; back-to-back transfers are one per cycle.
REQ-023 Completion SHALL be ignored when the tag is at least OP_TABLE_SIZE or names a free entry; otherwise the entry is freed and its queue q is no longer busy.
REQ-024 On completion, if len!=0 or pending[q]=1, q SHALL become eligible again and pending[q] is cleared; if len==0 and pending[q]=0, q becomes idle.
REQ-025 On simultaneous doorbell and completion for the same queue in one cycle, the doorbell SHALL count as pending, so the queue ends eligible.
REQ-026 A completion freeing an entry and an allocation in the same cycle SHALL be legal; the freed entry is usable from the next cycle.
REQ-027 With all OP_TABLE_SIZE entries in use, no pick SHALL occur; doorbells are still recorded.
REQ-028 enable=0 SHALL stop new picks only; a valid already presented stays valid, and completions and doorbells are still processed.
REQ-029 active SHALL be registered and equal 1 while any eligible bit, any used op entry, or the output valid is set.

Reset
REQ-030 Asserting rst (low) SHALL asynchronously clear all eligible/busy/pending bits, the op table and the pipeline, and set m_axis_tx_req_valid=0, queue=0, tag=0, active=0.
REQ-031 Reset mid-operation SHALL discard all outstanding ops; completions for them after reset are ignored.
REQ-032 After deassertion, the block SHALL be ready on the next edge with no initialization sweep.

Verification
REQ-033 Doorbell Q1, ready=1, enable=1 -> one request queue=1, tag=0 after PIPELINE+1 cycles; no further requests.
REQ-034 Then completion tag=2 len=0 -> ignored; doorbell Q2 -> request queue=2, tag=1; completions tag 1 then tag 0 with len=0 -> active=0.
REQ-035 Doorbells Q5, Q3, Q9 in the same idle window -> requests in order 3, 5, 9 with tags 0, 1, 2.
REQ-036 Doorbell Q4 while its op is busy, then completion len=0 -> Q4 is rescheduled exactly once; completion with len=100 also reschedules it.
REQ-037 Doorbells on 17 queues with no completions -> exactly 16 requests with tags 0-15; one completion -> the 17th queue is issued with the freed tag.
REQ-038 ready=0 for 5 cycles -> valid, queue and tag held constant; enable=0 -> no new valid after the current transfer.
